substitui_bytes: RTL and testbench

- AES SubBytes stage for a 128-bit state block.
- Each of the 16 bytes is independently replaced by its AES forward S-box value (FIPS-197).
- Result is registered: one cycle latency, one block per cycle throughput.
- Sits in the AES round datapath ahead of ShiftRows; purely data-driven, no key input.

---
 rtl/substitui_bytes_pkg.sv | 32 +++
 rtl/substitui_bytes_aes_sbox.sv | 11 +
 rtl/substitui_bytes.sv | 42 ++++
 tb/tb_substitui_bytes.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/substitui_bytes_pkg.sv
// Shared AES SubBytes definitions: block geometry and the forward S-box table.
// Also used by the key schedule's SubWord so both paths share one table.
package substitui_bytes_pkg;

  localparam int BLOCK_W = 128;
  localparam int NBYTES  = BLOCK_W / 8;

  // FIPS-197 forward S-box, indexed by the input byte.
  localparam logic [7:0] SBOX_TABLE [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/substitui_bytes_aes_sbox.sv
// Single-byte AES forward S-box: purely combinational table lookup.
module aes_sbox
  import substitui_bytes_pkg::*;
(
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);

  assign dout_o = sbox_lookup(din_i);

endmodule

// File: rtl/substitui_bytes.sv
// AES SubBytes over a 128-bit state: 16 independent S-box lanes feeding a
// registered output with a matching valid flag (1-cycle latency, full rate).
module substitui_bytes
  import substitui_bytes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] bloco,
  input  logic               in_valid,
  output logic [BLOCK_W-1:0] saida,
  output logic               out_valid
);

  logic [BLOCK_W-1:0] saida_d;
  logic [BLOCK_W-1:0] saida_q;
  logic               out_valid_q;

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    aes_sbox u_sbox (
      .din_i  (bloco[8*i +: 8]),
      .dout_o (saida_d[8*i +: 8])
    );
  end

  // The data register only loads on accepted blocks so saida holds between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      out_valid_q <= in_valid;
      if (in_valid) begin
        saida_q <= saida_d;
      end
    end
  end

  assign saida     = saida_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_substitui_bytes.sv
// Scoreboard bench for substitui_bytes; the reference S-box is derived
// independently from GF(2^8) inversion plus the AES affine transform.
module tb_substitui_bytes;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] bloco;
  logic         in_valid;
  logic [127:0] saida;
  logic         out_valid;

  typedef struct packed {
    logic         v;
    logic [127:0] d;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] model_saida;
  logic [7:0]   ref_sbox [256];
  int           n_checks = 0;
  int           n_errors = 0;

  substitui_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bloco     (bloco),
    .in_valid  (in_valid),
    .saida     (saida),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_ref();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] bx  = 8'(x);
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gf_mul(bx, 8'(y)) == 8'h01) inv = 8'(y);
      end
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox[b[8*i +: 8]];
    return r;
  endfunction

  // Drive one cycle at the falling edge, then compare the result one edge later.
  task automatic drive(input logic [127:0] b, input logic v);
    exp_t e;
    bloco    = b;
    in_valid = v;
    if (v) model_saida = ref_sub(b);
    sb_q.push_back('{v: v, d: model_saida});
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("out_valid", {127'b0, out_valid}, {127'b0, e.v});
    check("saida", saida, e.d);
  endtask

  initial begin
    logic [127:0] blk;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    bloco       = '0;
    model_saida = '0;
    build_ref();

    @(negedge clk);
    check("reset_saida", saida, 128'h0);
    check("reset_valid", {127'b0, out_valid}, 128'h0);
    rst_n = 1'b1;

    // Reference vector, then hold with new data and in_valid low.
    drive(128'h50414c41565241544553544543494652, 1'b1);
    check("refvec_lit", saida, 128'h53832983b10083206eed206e1a3b5a00);
    drive(128'h0123456789abcdef0011223344556677, 1'b0);
    check("refvec_hold", saida, 128'h53832983b10083206eed206e1a3b5a00);

    // Uniform blocks back-to-back.
    drive({16{8'h00}}, 1'b1);
    check("all00_lit", saida, {16{8'h63}});
    drive({16{8'hff}}, 1'b1);
    check("allff_lit", saida, {16{8'h16}});

    // Exhaustive sweep: block k carries byte 16k+i in lane i.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16 * k + i);
      drive(blk, 1'b1);
      if (k == 0) check("anchor_01", {120'b0, saida[15:8]}, 128'h7c);
      if (k == 5) check("anchor_53", {120'b0, saida[31:24]}, 128'hed);
    end

    drive({4{32'hdeadbeef}}, 1'b0);
    drive({4{32'hcafef00d}}, 1'b1);

    // Asynchronous reset between edges while out_valid is high.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_saida", saida, 128'h0);
    check("async_rst_valid", {127'b0, out_valid}, 128'h0);
    sb_q.delete();
    model_saida = '0;

    // In-flight block offered during reset must be discarded.
    bloco    = 128'h50414c41565241544553544543494652;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_saida", saida, 128'h0);
    check("rst_hold_valid", {127'b0, out_valid}, 128'h0);
    rst_n = 1'b1;

    for (int n = 0; n < 3; n++) drive({$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // First capture after reset release.
    for (int n = 0; n < 4; n++) drive({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    drive('0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
